// File: rtl/div_issue_ctrl_if.sv
// div_issue_ctrl_if: EX-stage request and shared-divider signals of div_issue_ctrl
interface div_issue_ctrl_if #(parameter int DATA_W = 32);
  logic              req_valid;
  logic [1:0]        req_op;
  logic [DATA_W-1:0] req_src1;
  logic [DATA_W-1:0] req_src2;
  logic              out_allowin;
  logic              flush;
  logic              req_ready;
  logic [DATA_W-1:0] res;
  logic              busy;
  logic              div_en;
  logic              div_signed;
  logic [DATA_W-1:0] div_dividend;
  logic [DATA_W-1:0] div_divisor;
  logic              div_clear;
  logic [DATA_W-1:0] div_quotient;
  logic [DATA_W-1:0] div_remainder;
  logic              div_complete;
  modport master (
    output req_valid, req_op, req_src1, req_src2, out_allowin, flush,
           div_quotient, div_remainder, div_complete,
    input  req_ready, res, busy, div_en, div_signed, div_dividend, div_divisor, div_clear
  );
  modport slave (
    input  req_valid, req_op, req_src1, req_src2, out_allowin, flush,
           div_quotient, div_remainder, div_complete,
    output req_ready, res, busy, div_en, div_signed, div_dividend, div_divisor, div_clear
  );
endinterface

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl: sequences DIV/DIVU/MOD/MODU onto a shared divider, short-circuiting
// divide-by-zero, signed overflow and repeats of the last operand pair.
module div_issue_ctrl #(
  parameter int DATA_W   = 32,
  parameter int CACHE_EN = 1
) (
  input logic             clk,
  input logic             reset,
  div_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [DATA_W-1:0] MIN = {1'b1, {(DATA_W-1){1'b0}}};
  state_t state, nxt;
  logic [1:0]        op;
  logic [DATA_W-1:0] a, b, q, r, c_a, c_b, c_q, c_r;
  logic              c_signed, c_valid, clr;
  logic              sgn, zero, ovf, hit, take;
  always_comb begin
    sgn  = ~bus.req_op[0];
    zero = bus.req_src2 == '0;
    ovf  = sgn && bus.req_src1 == MIN && &bus.req_src2;
    hit  = CACHE_EN != 0 && c_valid && bus.req_src1 == c_a && bus.req_src2 == c_b && sgn == c_signed;
    take = state == IDLE && bus.req_valid && !bus.flush;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = bus.flush ? IDLE :
          state == IDLE ? (bus.req_valid ? ((zero || ovf || hit) ? DONE : RUN) : IDLE) :
          state == RUN  ? (bus.div_complete ? DONE : RUN) :
                          (bus.out_allowin ? IDLE : DONE);
  // Special-case and cache-hit results are preloaded into q/r at acceptance; a RUN overwrites them.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op       <= '0;
      a        <= '0;
      b        <= '0;
      q        <= '0;
      r        <= '0;
      c_a      <= '0;
      c_b      <= '0;
      c_q      <= '0;
      c_r      <= '0;
      c_signed <= 1'b0;
      c_valid  <= 1'b0;
      clr      <= 1'b0;
    end else begin
      clr <= state == RUN && bus.flush;
      if (take) begin
        op <= bus.req_op;
        a  <= bus.req_src1;
        b  <= bus.req_src2;
        q  <= zero ? '1 : ovf ? MIN : c_q;
        r  <= zero ? bus.req_src1 : ovf ? '0 : c_r;
      end
      if (state == RUN && bus.div_complete && !bus.flush) begin
        q <= bus.div_quotient;
        r <= bus.div_remainder;
        if (CACHE_EN != 0) begin
          c_a      <= a;
          c_b      <= b;
          c_q      <= bus.div_quotient;
          c_r      <= bus.div_remainder;
          c_signed <= ~op[0];
          c_valid  <= 1'b1;
        end
      end
    end
  always_comb begin
    bus.req_ready    = state == DONE;
    bus.busy         = state != IDLE;
    bus.div_en       = state == RUN;
    bus.div_signed   = state == RUN && !op[0];
    bus.res          = state == DONE ? (op[1] ? r : q) : '0;
    bus.div_dividend = a;
    bus.div_divisor  = b;
    bus.div_clear    = clr;
  end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb_div_issue_ctrl: directed scoreboard bench for div_issue_ctrl with a fixed-latency divider model
module tb_div_issue_ctrl;
  localparam int W = 32;
  localparam int K = 33;
  localparam logic [W-1:0] MIN = 32'h8000_0000;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  div_issue_ctrl_if #(.DATA_W(W)) bus();
  div_issue_ctrl #(.DATA_W(W), .CACHE_EN(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int en_cnt = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // divider completes in the K-th enabled cycle
  always @(posedge clk) cnt <= bus.div_en ? cnt + 1 : 0;
  assign bus.div_complete = bus.div_en && cnt == K - 1;
  assign bus.div_quotient = bus.div_divisor == '0 ? '0 :
    bus.div_signed ? W'($signed(bus.div_dividend) / $signed(bus.div_divisor)) : bus.div_dividend / bus.div_divisor;
  assign bus.div_remainder = bus.div_divisor == '0 ? '0 :
    bus.div_signed ? W'($signed(bus.div_dividend) % $signed(bus.div_divisor)) : bus.div_dividend % bus.div_divisor;

  always @(negedge clk)
    if (!reset) begin
      if (bus.div_en) en_cnt++;
      if (bus.req_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready res=%0h expected=none", bus.res);
        end else begin
          check("res", bus.res, exp_q[0]);
          if (bus.out_allowin) void'(exp_q.pop_front());
        end
      end
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic outs_zero(input string name);
    check(name, {bus.req_ready, bus.busy, bus.div_en, bus.div_signed, bus.div_clear,
                 bus.res, bus.div_dividend, bus.div_divisor}, '0);
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] x, y, exp,
                       input int stall, lat, en);
    int n = 0;
    en_cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_src1 = x;
    bus.req_src2 = y;
    bus.out_allowin = 1'b0;
    exp_q.push_back(exp);
    do begin
      step();
      n++;
      if (n == 1) bus.req_src1 = ~x;
    end while (!bus.req_ready && n < 200);
    check("latency", n, lat);
    if (!bus.req_ready) exp_q.delete();
    repeat (stall) step();
    bus.out_allowin = 1'b1;
    step();
    bus.out_allowin = 1'b0;
    bus.req_valid = 1'b0;
    check("div_en_cycles", en_cnt, en);
    check("idle_after", {bus.busy, bus.req_ready}, 2'b00);
  endtask

  task automatic abort(input logic [1:0] op, input logic [W-1:0] x, y, input int at, input bit use_reset);
    en_cnt = 0;
    bus.req_valid = 1'b1;
    bus.req_op = op;
    bus.req_src1 = x;
    bus.req_src2 = y;
    repeat (at) step();
    check("running", {bus.div_en, bus.div_complete}, {1'b1, at == K});
    bus.req_valid = 1'b0;
    if (use_reset) begin
      reset = 1'b1;
      #1;
      outs_zero("reset_mid_run");
      step();
      reset = 1'b0;
      step();
      outs_zero("after_reset_release");
    end else begin
      bus.flush = 1'b1;
      step();
      bus.flush = 1'b0;
      check("flush_clear", {bus.div_clear, bus.busy, bus.req_ready, bus.div_en}, 4'b1000);
      check("flush_en_cycles", en_cnt, at);
      step();
      check("clear_one_cycle", {bus.div_clear, bus.busy}, 2'b00);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_src1 = '0;
    bus.req_src2 = '0;
    bus.out_allowin = 1'b0;
    bus.flush = 1'b0;
    repeat (3) step();
    outs_zero("reset_state");
    reset = 1'b0;
    step();
    outs_zero("idle_state");
    issue(2'b00, 100, 7, 14, 3, K + 1, K);
    issue(2'b10, 100, 7, 2, 0, 1, 0);
    issue(2'b01, 100, 7, 14, 0, K + 1, K);
    issue(2'b01, 5, 0, '1, 0, 1, 0);
    issue(2'b11, 5, 0, 5, 0, 1, 0);
    issue(2'b00, MIN, '1, MIN, 0, 1, 0);
    issue(2'b10, MIN, '1, 0, 1, 1, 0);
    bus.req_valid = 1'b1;
    bus.req_op = 2'b00;
    bus.req_src1 = 9;
    bus.req_src2 = 3;
    bus.flush = 1'b1;
    step();
    bus.req_valid = 1'b0;
    bus.flush = 1'b0;
    check("flush_idle_reject", {bus.busy, bus.div_en}, 2'b00);
    abort(2'b00, 1000, 3, 10, 1'b0);
    issue(2'b11, 100, 7, 2, 0, 1, 0);
    issue(2'b00, 1000, 3, 333, 1, K + 1, K);
    abort(2'b00, 77, 5, K, 1'b0);
    issue(2'b00, 77, 5, 15, 0, K + 1, K);
    abort(2'b01, 1000, 10, 5, 1'b1);
    issue(2'b00, 77, 5, 15, 0, K + 1, K);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
